// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and types for the Wishbone arbiter
//
// Purpose: arbiter state encoding and Wishbone bus width.
// Ports:   none (package).
package wb_pkg;

   localparam int WB_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2,
      ARB_ABORT  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/wb_timeout.sv
// rtl/wb_timeout.sv - saturating ack-timeout counter for the Wishbone arbiter
//
// Purpose: counts bus cycles spent waiting for an ack and flags the cycle
//          that makes the count equal to TIMEOUT.
// Ports:   clk, reset (async, active low)
//          clr  - return the count to zero (takes priority over en)
//          en   - this cycle is an unacknowledged grant cycle
//          hit  - combinational; this cycle is the TIMEOUT-th unacked cycle
module wb_timeout #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;

   // Count including the current cycle, held at all-ones once saturated.
   assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

   // TIMEOUT of zero disables the abort entirely.
   assign hit = (TIMEOUT != 0) && en && (cnt_inc == LIMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt_inc;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin Wishbone classic arbiter with ack timeout
//
// Purpose: shares one Wishbone slave between the fetch unit (m0) and the
//          load/store unit (m1); grant lasts for a whole cyc-framed cycle and
//          an unanswered transaction is aborted with an err pulse.
// Ports:   clk, reset (async, active low)
//          i_mX_cyc/stb/we/addr/data - master X request
//          o_mX_data/ack/err         - master X response
//          o_wb_cyc/stb/we/addr/data - to slave
//          i_wb_data, i_wb_ack       - from slave
//          o_owner                   - one-hot current owner (01 m0, 10 m1)
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_m0_cyc,
   input  logic            i_m0_stb,
   input  logic            i_m0_we,
   input  logic [WB_W-1:0] i_m0_addr,
   input  logic [WB_W-1:0] i_m0_data,
   output logic [WB_W-1:0] o_m0_data,
   output logic            o_m0_ack,
   output logic            o_m0_err,
   input  logic            i_m1_cyc,
   input  logic            i_m1_stb,
   input  logic            i_m1_we,
   input  logic [WB_W-1:0] i_m1_addr,
   input  logic [WB_W-1:0] i_m1_data,
   output logic [WB_W-1:0] o_m1_data,
   output logic            o_m1_ack,
   output logic            o_m1_err,
   output logic            o_wb_cyc,
   output logic            o_wb_stb,
   output logic            o_wb_we,
   output logic [WB_W-1:0] o_wb_addr,
   output logic [WB_W-1:0] o_wb_data,
   input  logic [WB_W-1:0] i_wb_data,
   input  logic            i_wb_ack,
   output logic [1:0]      o_owner
);

   arb_state_t      state, state_nxt;
   logic            last_served, last_nxt;
   logic            own_sel;
   logic            own_cyc, own_stb, own_we;
   logic [WB_W-1:0] own_addr, own_data;
   logic            in_grant;
   logic            slave_cyc;
   logic            to_clr, to_en, to_hit;

   assign in_grant = (state == ARB_GRANT0) || (state == ARB_GRANT1);

   // In ABORT the owner is remembered through last_served, which was set on
   // grant entry and cannot change until the arbiter is back in IDLE.
   assign own_sel  = (state == ARB_GRANT1) || ((state == ARB_ABORT) && last_served);

   assign own_cyc  = own_sel ? i_m1_cyc  : i_m0_cyc;
   assign own_stb  = own_sel ? i_m1_stb  : i_m0_stb;
   assign own_we   = own_sel ? i_m1_we   : i_m0_we;
   assign own_addr = own_sel ? i_m1_addr : i_m0_addr;
   assign own_data = own_sel ? i_m1_data : i_m0_data;

   // An ack in the counter-hit cycle keeps en low, so ack always beats err.
   assign to_en  = in_grant && own_cyc && !i_wb_ack;
   assign to_clr = !in_grant || i_wb_ack;

   wb_timeout #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr   (to_clr),
      .en    (to_en),
      .hit   (to_hit)
   );

   // Read data is broadcast; only the ack tells a master it is valid.
   assign o_m0_data = i_wb_data;
   assign o_m1_data = i_wb_data;

   assign slave_cyc = in_grant && own_cyc && !to_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ARB_IDLE;
         last_served <= 1'b1;
      end else begin
         state       <= state_nxt;
         last_served <= last_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      last_nxt  = last_served;
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_addr = '0;
      o_wb_data = '0;
      o_m0_ack  = 1'b0;
      o_m1_ack  = 1'b0;
      o_m0_err  = 1'b0;
      o_m1_err  = 1'b0;
      o_owner   = 2'b00;

      case (state)
         ARB_IDLE: begin
            // With both requesting, m0 wins only if m1 was served last.
            if (i_m0_cyc && (!i_m1_cyc || last_served)) begin
               state_nxt = ARB_GRANT0;
               last_nxt  = 1'b0;
            end else if (i_m1_cyc) begin
               state_nxt = ARB_GRANT1;
               last_nxt  = 1'b1;
            end
         end

         ARB_GRANT0, ARB_GRANT1: begin
            o_wb_cyc  = slave_cyc;
            o_wb_stb  = own_stb && !to_hit;
            o_wb_we   = own_we;
            o_wb_addr = own_addr;
            o_wb_data = own_data;
            o_owner   = own_sel ? 2'b10 : 2'b01;
            o_m0_ack  = !own_sel && i_wb_ack && slave_cyc;
            o_m1_ack  =  own_sel && i_wb_ack && slave_cyc;
            o_m0_err  = !own_sel && to_hit;
            o_m1_err  =  own_sel && to_hit;
            if (to_hit) begin
               state_nxt = ARB_ABORT;
            end else if (!own_cyc) begin
               state_nxt = ARB_IDLE;
            end
         end

         ARB_ABORT: begin
            o_owner = own_sel ? 2'b10 : 2'b01;
            if (!own_cyc) begin
               state_nxt = ARB_IDLE;
            end
         end

         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_m0_cyc, i_m0_stb, i_m0_we;
   logic [31:0] i_m0_addr, i_m0_data, o_m0_data;
   logic        o_m0_ack, o_m0_err;
   logic        i_m1_cyc, i_m1_stb, i_m1_we;
   logic [31:0] i_m1_addr, i_m1_data, o_m1_data;
   logic        o_m1_ack, o_m1_err;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [31:0] o_wb_addr, o_wb_data, i_wb_data;
   logic        i_wb_ack;
   logic [1:0]  o_owner;

   always #5 clk = ~clk;

   wb_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_m0_cyc  (i_m0_cyc),
      .i_m0_stb  (i_m0_stb),
      .i_m0_we   (i_m0_we),
      .i_m0_addr (i_m0_addr),
      .i_m0_data (i_m0_data),
      .o_m0_data (o_m0_data),
      .o_m0_ack  (o_m0_ack),
      .o_m0_err  (o_m0_err),
      .i_m1_cyc  (i_m1_cyc),
      .i_m1_stb  (i_m1_stb),
      .i_m1_we   (i_m1_we),
      .i_m1_addr (i_m1_addr),
      .i_m1_data (i_m1_data),
      .o_m1_data (o_m1_data),
      .o_m1_ack  (o_m1_ack),
      .o_m1_err  (o_m1_err),
      .o_wb_cyc  (o_wb_cyc),
      .o_wb_stb  (o_wb_stb),
      .o_wb_we   (o_wb_we),
      .o_wb_addr (o_wb_addr),
      .o_wb_data (o_wb_data),
      .i_wb_data (i_wb_data),
      .i_wb_ack  (i_wb_ack),
      .o_owner   (o_owner)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: owner is 0 (nobody), 1 (m0) or 2 (m1).
   int own   = 0;
   bit abrt  = 1'b0;
   int last  = 1;
   int waits = 0;

   // Values seen during the most recent step, for directed checks.
   logic        s_wb_cyc, s_wb_we, s_m0_ack, s_m1_ack, s_m0_err, s_m1_err;
   logic [31:0] s_wb_data, s_m0_data;
   logic [1:0]  s_owner;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      #2;
      reset = 1'b0;
      #1;
      own = 0; abrt = 1'b0; last = 1; waits = 0;
      chk("rst_wb_cyc", 32'(o_wb_cyc), 32'd0);
      chk("rst_wb_stb", 32'(o_wb_stb), 32'd0);
      chk("rst_owner",  32'(o_owner),  32'd0);
      chk("rst_m0_err", 32'(o_m0_err), 32'd0);
      chk("rst_m1_err", 32'(o_m1_err), 32'd0);
      chk("rst_m0_ack", 32'(o_m0_ack), 32'd0);
      chk("rst_m1_ack", 32'(o_m1_ack), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // One clock: check outputs at the falling edge against the model, then
   // advance the model by the arbitration rules at the rising edge.
   task automatic step();
      logic        oc, os, ow, hit;
      logic [31:0] oa, od;
      logic        ecyc, estb, ewe, ea0, ea1, ee0, ee1;
      logic [31:0] eaddr, edata;
      logic [1:0]  eown;
      @(negedge clk);
      oc = (own == 2) ? i_m1_cyc  : i_m0_cyc;
      os = (own == 2) ? i_m1_stb  : i_m0_stb;
      ow = (own == 2) ? i_m1_we   : i_m0_we;
      oa = (own == 2) ? i_m1_addr : i_m0_addr;
      od = (own == 2) ? i_m1_data : i_m0_data;
      {hit, ecyc, estb, ewe, ea0, ea1, ee0, ee1} = '0;
      eaddr = '0;
      edata = '0;
      if (own != 0 && !abrt) begin
         hit   = (TO > 0) && oc && !i_wb_ack && (waits + 1 == TO);
         ecyc  = oc && !hit;
         estb  = os && !hit;
         ewe   = ow;
         eaddr = oa;
         edata = od;
         if (own == 1) begin
            ea0 = i_wb_ack && ecyc;
            ee0 = hit;
         end else begin
            ea1 = i_wb_ack && ecyc;
            ee1 = hit;
         end
      end
      eown = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;

      s_wb_cyc = o_wb_cyc;  s_wb_we  = o_wb_we;  s_wb_data = o_wb_data;
      s_m0_ack = o_m0_ack;  s_m1_ack = o_m1_ack;
      s_m0_err = o_m0_err;  s_m1_err = o_m1_err;
      s_m0_data = o_m0_data; s_owner = o_owner;

      chk("wb_cyc",  32'(o_wb_cyc), 32'(ecyc));
      chk("wb_stb",  32'(o_wb_stb), 32'(estb));
      chk("wb_we",   32'(o_wb_we),  32'(ewe));
      chk("wb_addr", o_wb_addr, eaddr);
      chk("wb_data", o_wb_data, edata);
      chk("m0_ack",  32'(o_m0_ack), 32'(ea0));
      chk("m1_ack",  32'(o_m1_ack), 32'(ea1));
      chk("m0_err",  32'(o_m0_err), 32'(ee0));
      chk("m1_err",  32'(o_m1_err), 32'(ee1));
      chk("m0_data", o_m0_data, i_wb_data);
      chk("m1_data", o_m1_data, i_wb_data);
      chk("owner",   32'(o_owner), 32'(eown));

      @(posedge clk);
      if (own == 0) begin
         if (i_m0_cyc && i_m1_cyc) own = (last == 1) ? 1 : 2;
         else if (i_m0_cyc)        own = 1;
         else if (i_m1_cyc)        own = 2;
         if (own != 0) begin
            last  = own - 1;
            waits = 0;
         end
      end else if (!abrt) begin
         if (hit)           abrt  = 1'b1;
         else if (!oc)      own   = 0;
         else if (i_wb_ack) waits = 0;
         else               waits = waits + 1;
      end else if (!oc) begin
         own  = 0;
         abrt = 1'b0;
      end
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      i_m0_cyc  = 1'b0; i_m0_stb = 1'b0; i_m0_we = 1'b0; i_m0_addr = '0; i_m0_data = '0;
      i_m1_cyc  = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0; i_m1_addr = '0; i_m1_data = '0;
      i_wb_ack  = 1'b0; i_wb_data = '0;
      apply_reset();

      // m0 alone reads 0x10, slave acks on the third grant cycle
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b0; i_m0_addr = 32'h10;
      step();
      chk("t1_req_cyc", 32'(s_wb_cyc), 32'd0);
      step();
      chk("t1_grant_cyc", 32'(s_wb_cyc), 32'd1);
      chk("t1_owner", 32'(s_owner), 32'd1);
      step();
      i_wb_ack = 1'b1; i_wb_data = 32'hDEADBEEF;
      step();
      chk("t1_ack", 32'(s_m0_ack), 32'd1);
      chk("t1_data", s_m0_data, 32'hDEADBEEF);
      chk("t1_m1_ack", 32'(s_m1_ack), 32'd0);
      i_wb_ack = 1'b0; i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
      step();
      step();

      // simultaneous requests alternate starting with m0 after reset
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 32'h100 + 32'(i);
         i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 32'h200 + 32'(i);
         step();
         step();
         chk($sformatf("t2_owner%0d", i), 32'(s_owner), (i % 2 == 0) ? 32'd1 : 32'd2);
         i_wb_ack = 1'b1; i_wb_data = $urandom;
         step();
         i_wb_ack = 1'b0;
         i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
         step();
      end

      // m1 write is not pre-empted by m0; one dead cycle before m0
      i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b1;
      i_m1_addr = 32'h20; i_m1_data = 32'h12345678;
      step();
      step();
      chk("t3_we", 32'(s_wb_we), 32'd1);
      chk("t3_wdata", s_wb_data, 32'h12345678);
      chk("t3_owner", 32'(s_owner), 32'd2);
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b0; i_m0_addr = 32'h30;
      step();
      chk("t3_keep", 32'(s_owner), 32'd2);
      i_wb_ack = 1'b1;
      step();
      chk("t3_m1_ack", 32'(s_m1_ack), 32'd1);
      chk("t3_m0_ack", 32'(s_m0_ack), 32'd0);
      i_wb_ack = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0; i_m1_we = 1'b0;
      step();
      step();
      chk("t3_dead_owner", 32'(s_owner), 32'd0);
      chk("t3_dead_cyc", 32'(s_wb_cyc), 32'd0);
      step();
      chk("t3_m0_owner", 32'(s_owner), 32'd1);
      i_wb_ack = 1'b1;
      step();
      i_wb_ack = 1'b0; i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
      step();

      // slave never acks m0: err on 4th unacked cycle, ABORT, then m1
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 32'h40;
      step();
      step();
      step();
      i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 32'h44;
      step();
      step();
      chk("t4_err", 32'(s_m0_err), 32'd1);
      chk("t4_cyc", 32'(s_wb_cyc), 32'd0);
      chk("t4_m1_err", 32'(s_m1_err), 32'd0);
      step();
      chk("t4_abort_owner", 32'(s_owner), 32'd1);
      chk("t4_abort_cyc", 32'(s_wb_cyc), 32'd0);
      chk("t4_err_once", 32'(s_m0_err), 32'd0);
      step();
      i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
      step();
      step();
      chk("t4_idle_owner", 32'(s_owner), 32'd0);
      step();
      chk("t4_m1_owner", 32'(s_owner), 32'd2);
      chk("t4_m1_cyc", 32'(s_wb_cyc), 32'd1);
      i_wb_ack = 1'b1;
      step();
      i_wb_ack = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
      step();

      // ack lands on the counter-hit cycle: ack wins, grant kept
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_addr = 32'h50;
      step();
      step();
      step();
      step();
      i_wb_ack = 1'b1; i_wb_data = 32'hA5A5_5A5A;
      step();
      chk("t5_ack", 32'(s_m0_ack), 32'd1);
      chk("t5_err", 32'(s_m0_err), 32'd0);
      i_wb_ack = 1'b0;
      step();
      chk("t5_owner", 32'(s_owner), 32'd1);
      chk("t5_err_after", 32'(s_m0_err), 32'd0);
      i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
      step();

      // reset mid-GRANT1, then round-robin restarts at m0
      i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 32'h60;
      step();
      step();
      apply_reset();
      i_m0_cyc = 1'b1; i_m0_stb = 1'b1;
      step();
      step();
      chk("t6_owner", 32'(s_owner), 32'd1);
      i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
      step();
      step();

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         if (i_m0_cyc) begin
            if (s_m0_err || ($urandom_range(0, 15) == 0)) begin
               i_m0_cyc = 1'b0;
            end else if (s_m0_ack) begin
               if ($urandom_range(0, 1) == 0) begin
                  i_m0_cyc = 1'b0;
               end else begin
                  i_m0_addr = $urandom; i_m0_data = $urandom;
                  i_m0_we = 1'($urandom_range(0, 1));
               end
            end
         end else if ($urandom_range(0, 2) == 0) begin
            i_m0_cyc = 1'b1; i_m0_addr = $urandom; i_m0_data = $urandom;
            i_m0_we = 1'($urandom_range(0, 1));
         end
         i_m0_stb = i_m0_cyc;

         if (i_m1_cyc) begin
            if (s_m1_err || ($urandom_range(0, 15) == 0)) begin
               i_m1_cyc = 1'b0;
            end else if (s_m1_ack) begin
               if ($urandom_range(0, 1) == 0) begin
                  i_m1_cyc = 1'b0;
               end else begin
                  i_m1_addr = $urandom; i_m1_data = $urandom;
                  i_m1_we = 1'($urandom_range(0, 1));
               end
            end
         end else if ($urandom_range(0, 2) == 0) begin
            i_m1_cyc = 1'b1; i_m1_addr = $urandom; i_m1_data = $urandom;
            i_m1_we = 1'($urandom_range(0, 1));
         end
         i_m1_stb = i_m1_cyc;

         i_wb_ack  = ($urandom_range(0, 3) == 0);
         i_wb_data = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-master / one-slave Wishbone (classic, non-pipelined) arbiter sharing the CPU memory bus.
- Master 0 is the instruction fetch unit; master 1 is the load/store unit.
- Round-robin grant, held for a full bus cycle (cyc-framed), with a per-transaction ack timeout that returns an error to the owning master.

Parameters:
- TIMEOUT, 255, cycles without ack before abort; 0 disables the timeout.
- CNT_W, 8, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 request
- i_m0_addr, i_m0_data  in  32 each  master 0 address / write data
- o_m0_data  out  32  read data to master 0
- o_m0_ack, o_m0_err  out  1 each  master 0 acknowledge / timeout error
- i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_data, o_m1_data, o_m1_ack, o_m1_err  (same as m0)  master 1
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  to slave
- o_wb_addr, o_wb_data  out  32 each  to slave
- i_wb_data  in  32  slave read data
- i_wb_ack  in  1  slave acknowledge
- o_owner  out  2  one-hot current owner (01 = m0, 10 = m1, 00 = none)

Behaviour:
- States: IDLE, GRANT0, GRANT1, ABORT.
- Reset (asynchronous, reset low):
  - state = IDLE, last_served = 1, timeout counter = 0, all err = 0.
  - All slave-side outputs are 0 while in IDLE/ABORT.
- IDLE:
  - Sample cyc of both masters on the clock edge.
  - Exactly one requesting: go to that master's GRANT state.
  - Both requesting: grant the master != last_served.
  - Neither requesting: stay in IDLE.
  - Arbitration latency is 1 clock (request seen at edge N, slave sees cyc from cycle N+1).
- GRANTx:
  - o_wb_cyc/stb/we/addr/data are combinational copies of the owner's signals.
  - o_mx_ack = i_wb_ack & o_wb_cyc; ack to the non-owner is always 0.
  - o_m0_data and o_m1_data = i_wb_data (broadcast); only ack qualifies it.
  - last_served updates to x on grant entry.
  - Grant persists across multiple stb/ack beats as long as the owner holds cyc.
  - Owner cyc low at an edge: go to IDLE (one dead cycle before the next grant). The other master cannot pre-empt.
- Timeout (TIMEOUT > 0):
  - Counter increments each GRANT cycle without i_wb_ack; clears on ack and on grant entry.
  - When counter reaches TIMEOUT, in the same cycle: o_mx_err = 1 for exactly one clock, slave cyc/stb forced 0.
  - Next state is ABORT.
  - Ack and counter-hit in the same cycle: ack wins, no err.
- ABORT:
  - Slave signals held 0.
  - Wait for the aborted owner's cyc = 0, then go to IDLE.
  - Requests from the other master are deferred until then.
- Other rules:
  - i_wb_ack arriving in IDLE/ABORT is ignored (no master ack).
  - o_owner reflects state combinationally; ABORT reports the aborted owner.
  - Reset asserted mid-transaction: slave cyc drops immediately (asynchronous); no ack or err is generated.
  - Widths: counter CNT_W bits and saturates; comparison is equality against TIMEOUT.

Decomposition:
- Shared package `wb_pkg`:
  - state encoding constants (ARB_IDLE = 2'd0, ARB_GRANT0 = 2'd1, ARB_GRANT1 = 2'd2, ARB_ABORT = 2'd3);
  - Wishbone address/data width constant WB_W = 32.
- One natural sub-module `wb_timeout`: counter with clear/enable inputs and a hit output, parameterised by TIMEOUT/CNT_W. The mux and FSM stay in wb_arbiter.

Test Plan:
- m0 alone reads addr 0x0000_0010, slave acks after 2 cycles with 0xDEADBEEF -> o_wb_cyc rises 1 clk after i_m0_cyc; o_m0_ack 1 clk with o_m0_data = 0xDEADBEEF; o_m1_ack stays 0; o_owner = 01.
- m0 and m1 assert cyc on the same edge after reset -> m0 granted first. Next simultaneous request -> m1 granted. Third -> m0 (alternation verified across 6 transactions).
- m1 writes 0x1234_5678 to 0x20 while m0 raises cyc mid-transaction -> m1 keeps the grant until it drops cyc; m0 granted after exactly 1 idle cycle; o_wb_we/data match m1 during its grant.
- TIMEOUT = 4, slave never acks m0 -> o_m0_err pulses 1 clk on the 4th unacked cycle; o_wb_cyc = 0 from that cycle; state holds ABORT until i_m0_cyc = 0; pending m1 then granted.
- Ack on the same cycle the counter hits TIMEOUT -> o_m0_ack = 1, o_m0_err = 0, grant retained.
- Assert reset low mid-GRANT1 -> o_wb_cyc = 0 and o_owner = 00 without waiting for clk; after release, first simultaneous request grants m0.
